// File: rtl/z88_memctl.sv
// z88_memctl - memory controller for the blink chip-select glue.
//
// Converts the blink's combinational read/write strobes into one
// request/acknowledge transaction on a shared external memory port. The Z80
// is stalled with wait_n until the port answers. Writes to read-only
// selects are dropped without touching the port.
//
// Optional feature: define Z88_MEMCTL_TIMEOUT_EN to abort a request that
// gets no mem_ack within TIMEOUT cycles. The abort raises the sticky err flag.
// Without the macro, err is tied low and a request waits for mem_ack forever.
//
// Ports:
//   clk      master clock
//   reset_n  asynchronous active-low reset
//   ma       banked address from the blink (AW bits)
//   cs_n     active-low chip selects: bit0 ROM, bit1 RAM, bits 2.. card slots
//   roe_n    read strobe, active low
//   wrb_n    write strobe, active low
//   cdo      CPU write data
//   cdi      read data to the CPU data mux (8'hFF when not driving)
//   wait_n   Z80 wait, active low
//   mem_req  external request, held until mem_ack
//   mem_we   1 = write transaction
//   mem_sel  encoded chip-select index
//   mem_a    latched address
//   mem_wd   latched write data
//   mem_rd   external read data, valid with mem_ack
//   mem_ack  single-cycle acknowledge
//   err      sticky timeout flag
module z88_memctl #(
  parameter int unsigned      NCS     = 5,
  parameter int unsigned      AW      = 22,
  parameter logic [NCS-1:0]   RO_MASK = 5'b00001,
  parameter int unsigned      TIMEOUT = 255,
  parameter int unsigned      TOW     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [AW-1:0]            ma,
  input  logic [NCS-1:0]           cs_n,
  input  logic                     roe_n,
  input  logic                     wrb_n,
  input  logic [7:0]               cdo,
  output logic [7:0]               cdi,
  output logic                     wait_n,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [$clog2(NCS)-1:0]   mem_sel,
  output logic [AW-1:0]            mem_a,
  output logic [7:0]               mem_wd,
  input  logic [7:0]               mem_rd,
  input  logic                     mem_ack,
  output logic                     err
);

  localparam int unsigned SW = $clog2(NCS);

  // The abort counter must be able to hold TIMEOUT.
  if (TIMEOUT >= 2**TOW) begin : g_timeout_range
    $error("z88_memctl: TIMEOUT must be below 2**TOW");
  end

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [7:0]      mem_wd_q, mem_wd_d;
  logic [SW-1:0]   mem_sel_q, mem_sel_d;
  logic            mem_we_q, mem_we_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            strobe;
  logic            wr_req;
  logic [SW-1:0]   sel_enc;
  logic            ro_block;

  // Lowest-numbered active select wins. The loop runs downward, so the
  // last assignment comes from the lowest index.
  always_comb begin
    sel_enc = '0;
    for (int i = NCS - 1; i >= 0; i--) begin
      if (!cs_n[i]) sel_enc = SW'(i);
    end
  end

  // Both strobes low counts as a write.
  assign wr_req   = !wrb_n;
  assign strobe   = (!roe_n || !wrb_n) && !(&cs_n);
  assign ro_block = wr_req && RO_MASK[sel_enc];

`ifdef Z88_MEMCTL_TIMEOUT_EN
  logic [TOW-1:0]  cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mem_a_q   <= '0;
      mem_wd_q  <= '0;
      mem_sel_q <= '0;
      mem_we_q  <= 1'b0;
      rdata_q   <= 8'hFF;
`ifdef Z88_MEMCTL_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_a_q   <= mem_a_d;
      mem_wd_q  <= mem_wd_d;
      mem_sel_q <= mem_sel_d;
      mem_we_q  <= mem_we_d;
      rdata_q   <= rdata_d;
`ifdef Z88_MEMCTL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    mem_a_d   = mem_a_q;
    mem_wd_d  = mem_wd_q;
    mem_sel_d = mem_sel_q;
    mem_we_d  = mem_we_q;
    rdata_d   = rdata_q;
`ifdef Z88_MEMCTL_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          mem_a_d   = ma;
          mem_wd_d  = cdo;
          mem_sel_d = sel_enc;
          mem_we_d  = wr_req;
          // Clear stale data so cdi reads 8'hFF until this transaction answers.
          rdata_d   = 8'hFF;
`ifdef Z88_MEMCTL_TIMEOUT_EN
          cnt_d     = '0;
`endif
          state_d   = ro_block ? HOLD : REQ;
        end
      end
      REQ: begin
        // A strobe that goes away here does not cancel the request.
        if (mem_ack) begin
          rdata_d = mem_rd;
          state_d = HOLD;
        end
`ifdef Z88_MEMCTL_TIMEOUT_EN
        // The count is 0 in the first REQ cycle. This compare ends the wait
        // after TIMEOUT REQ cycles.
        else if (cnt_q == TOW'(TIMEOUT - 1)) begin
          rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        // Wait for the CPU cycle to end, so each cycle gets one transaction.
        if (!strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wait_n  = 1'b1;
    mem_req = 1'b0;
    unique case (state_q)
      // Stall from the CPU's first sample of the strobe. Reset holds wait_n high.
      IDLE:    wait_n = !(strobe && !ro_block && reset_n);
      REQ: begin
        wait_n  = 1'b0;
        mem_req = 1'b1;
      end
      default: wait_n = 1'b1;
    endcase
    cdi = (!roe_n && (state_q != IDLE)) ? rdata_q : 8'hFF;
  end

  assign mem_a   = mem_a_q;
  assign mem_wd  = mem_wd_q;
  assign mem_sel = mem_sel_q;
  assign mem_we  = mem_we_q;

`ifdef Z88_MEMCTL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_z88_memctl.sv
module tb_z88_memctl;

  localparam int NCS = 5;
  localparam int AW  = 22;
  localparam int TO  = 8;
  localparam logic [NCS-1:0] RO = 5'b00001;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [AW-1:0]  ma;
  logic [NCS-1:0] cs_n;
  logic           roe_n;
  logic           wrb_n;
  logic [7:0]     cdo;
  logic [7:0]     cdi;
  logic           wait_n;
  logic           mem_req;
  logic           mem_we;
  logic [2:0]     mem_sel;
  logic [AW-1:0]  mem_a;
  logic [7:0]     mem_wd;
  logic [7:0]     mem_rd = 8'h00;
  logic           mem_ack = 1'b0;
  logic           err;

  z88_memctl #(.NCS(NCS), .AW(AW), .RO_MASK(RO), .TIMEOUT(TO), .TOW(8)) dut (
    .clk(clk), .reset_n(reset_n), .ma(ma), .cs_n(cs_n), .roe_n(roe_n),
    .wrb_n(wrb_n), .cdo(cdo), .cdi(cdi), .wait_n(wait_n), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory-side responder: ack in REQ cycle number ack_delay (1 = first),
  // never when ack_delay is 0. inject_ack forces an ack outside a request.
  int         ack_delay = 0;
  logic       inject_ack = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int         req_cyc = 0;
  always @(negedge clk) begin
    mem_rd <= rd_val;
    if (mem_req) begin
      mem_ack <= (ack_delay != 0) && (req_cyc + 1 == ack_delay);
      req_cyc <= req_cyc + 1;
    end else begin
      mem_ack <= inject_ack;
      req_cyc <= 0;
    end
  end

  // Count rising edges of mem_req.
  int   req_rises = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= mem_req;
  end

  // Values observed during one CPU transaction
  int            obs_wait_low, obs_pulses;
  logic          obs_timeout, obs_unstable, obs_seen;
  logic [2:0]    obs_sel;
  logic          obs_we;
  logic [AW-1:0] obs_a;
  logic [7:0]    obs_wd, obs_cdi_hold, obs_cdi_after;

  // Reference: index of the lowest active chip select.
  function automatic int model_sel(input logic [NCS-1:0] cs);
    for (int i = 0; i < NCS; i++) if (!cs[i]) return i;
    return -1;
  endfunction

  // Drives one CPU access and records what the DUT does. It makes no judgements.
  task automatic run_txn(input logic [NCS-1:0] cs, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [7:0] d,
                         input int ackd, input logic [7:0] rdv, input int extra);
    int start;
    bit done;
    @(posedge clk); #1;
    ma = a; cs_n = cs; roe_n = !rd; wrb_n = !wr; cdo = d;
    ack_delay = ackd; rd_val = rdv;
    start = req_rises;
    obs_wait_low = 0; obs_unstable = 1'b0; obs_seen = 1'b0; done = 1'b0;
    obs_sel = '0; obs_we = 1'b0; obs_a = '0; obs_wd = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (obs_seen && (obs_sel !== mem_sel || obs_we !== mem_we ||
                         obs_a !== mem_a || obs_wd !== mem_wd)) obs_unstable = 1'b1;
        obs_seen = 1'b1;
        obs_sel = mem_sel; obs_we = mem_we; obs_a = mem_a; obs_wd = mem_wd;
      end
      if (wait_n === 1'b0) obs_wait_low++;
      else done = 1'b1;
    end
    obs_timeout = !done;
    obs_cdi_hold = cdi;
    repeat (extra) @(negedge clk);
    @(posedge clk); #1;
    roe_n = 1'b1; wrb_n = 1'b1; cs_n = '1; ack_delay = 0;
    @(negedge clk);
    obs_cdi_after = cdi;
    obs_pulses = req_rises - start;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
    checks++; if (cdi !== 8'hFF) begin errors++; $display("FAIL reset_cdi: got %h want ff", cdi); end
    checks++; if ({mem_we, mem_sel, mem_a, mem_wd} !== '0) begin errors++;
      $display("FAIL reset_port: got we=%b sel=%0d a=%h wd=%h want all 0", mem_we, mem_sel, mem_a, mem_wd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || wait_n !== 1'b1) begin errors++;
      $display("FAIL reset_idle: got req=%b wait_n=%b want 0/1", mem_req, wait_n); end
  endtask

  task automatic test_rom_read();
    run_txn(5'b11110, 1'b1, 1'b0, 22'h000123, 8'h00, 3, 8'hA5, 2);
    checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL rom_done: wait_n never released"); end
    checks++; if (obs_sel !== 3'd0 || obs_we !== 1'b0) begin errors++;
      $display("FAIL rom_sel_we: got sel=%0d we=%b want 0/0", obs_sel, obs_we); end
    checks++; if (obs_a !== 22'h000123) begin errors++; $display("FAIL rom_addr: got %h want 000123", obs_a); end
    checks++; if (obs_wait_low != 4) begin errors++; $display("FAIL rom_wait: got %0d cycles want 4", obs_wait_low); end
    checks++; if (obs_cdi_hold !== 8'hA5) begin errors++; $display("FAIL rom_cdi: got %h want a5", obs_cdi_hold); end
    checks++; if (obs_cdi_after !== 8'hFF) begin errors++; $display("FAIL rom_cdi_after: got %h want ff", obs_cdi_after); end
  endtask

  task automatic test_ram_write();
    run_txn(5'b11101, 1'b0, 1'b1, 22'h2ABCDE, 8'h3C, 1, 8'h77, 10);
    checks++; if (obs_we !== 1'b1 || obs_sel !== 3'd1) begin errors++;
      $display("FAIL ram_sel_we: got sel=%0d we=%b want 1/1", obs_sel, obs_we); end
    checks++; if (obs_wd !== 8'h3C) begin errors++; $display("FAIL ram_wd: got %h want 3c", obs_wd); end
    checks++; if (obs_pulses != 1) begin errors++; $display("FAIL ram_pulses: got %0d want 1", obs_pulses); end
    checks++; if (obs_wait_low != 2) begin errors++; $display("FAIL ram_wait: got %0d cycles want 2", obs_wait_low); end
  endtask

  task automatic test_ro_write();
    run_txn(5'b11110, 1'b0, 1'b1, 22'h000010, 8'h55, 1, 8'h12, 3);
    checks++; if (obs_pulses != 0) begin errors++; $display("FAIL ro_pulses: got %0d want 0", obs_pulses); end
    checks++; if (obs_wait_low != 0) begin errors++; $display("FAIL ro_wait: got %0d cycles want 0", obs_wait_low); end
    checks++; if (obs_cdi_hold !== 8'hFF) begin errors++; $display("FAIL ro_cdi: got %h want ff", obs_cdi_hold); end
  endtask

  task automatic test_priority();
    run_txn(5'b11000, 1'b1, 1'b0, 22'h001000, 8'h00, 2, 8'h9E, 0);
    checks++; if (obs_sel !== 3'd0) begin errors++; $display("FAIL prio_sel: got %0d want 0", obs_sel); end
    run_txn(5'b11101, 1'b1, 1'b1, 22'h001001, 8'hC3, 1, 8'h00, 0);
    checks++; if (obs_we !== 1'b1 || obs_pulses != 1) begin errors++;
      $display("FAIL both_strobes: got we=%b pulses=%0d want 1/1", obs_we, obs_pulses); end
  endtask

  task automatic test_strobe_drop();
    int start, n;
    @(posedge clk); #1;
    ma = 22'h0ABCDE; cs_n = 5'b11011; roe_n = 1'b0; wrb_n = 1'b1; ack_delay = 4; rd_val = 8'h42;
    start = req_rises;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    roe_n = 1'b1; cs_n = '1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_sel !== 3'd2) begin errors++;
      $display("FAIL drop_keep_req: got req=%b sel=%0d want 1/2", mem_req, mem_sel); end
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || wait_n !== 1'b1 || cdi !== 8'hFF) begin errors++;
      $display("FAIL drop_exit: got req=%b wait_n=%b cdi=%h want 0/1/ff", mem_req, wait_n, cdi); end
    checks++; if (req_rises - start != 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", req_rises - start); end
    ack_delay = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [NCS-1:0] cs;
      logic [AW-1:0]  a;
      logic [7:0]     d, rdv;
      logic           rd, wr, blocked;
      int             mode, ackd, sel, exp_wait;
      do cs = NCS'($urandom); while (cs == '1);
      mode = $urandom_range(0, 2);
      rd = (mode != 1); wr = (mode != 0);
      sel = model_sel(cs);
      blocked = wr && RO[sel];
      ackd = $urandom_range(1, 4);
      a = AW'($urandom); d = 8'($urandom); rdv = 8'($urandom);
      exp_wait = blocked ? 0 : 1 + ackd;
      run_txn(cs, rd, wr, a, d, ackd, rdv, $urandom_range(0, 3));
      checks++; if (obs_wait_low != exp_wait) begin errors++;
        $display("FAIL rnd_wait[%0d]: got %0d want %0d", n, obs_wait_low, exp_wait); end
      checks++; if (obs_pulses != (blocked ? 0 : 1)) begin errors++;
        $display("FAIL rnd_pulses[%0d]: got %0d want %0d", n, obs_pulses, blocked ? 0 : 1); end
      if (!blocked) begin
        checks++; if (obs_sel !== 3'(sel) || obs_we !== wr || obs_a !== a || obs_unstable !== 1'b0) begin errors++;
          $display("FAIL rnd_port[%0d]: got sel=%0d we=%b a=%h unstable=%b want %0d/%b/%h/0",
                   n, obs_sel, obs_we, obs_a, obs_unstable, sel, wr, a); end
        if (wr) begin
          checks++; if (obs_wd !== d) begin errors++; $display("FAIL rnd_wd[%0d]: got %h want %h", n, obs_wd, d); end
        end
      end
      if (mode != 2 || blocked) begin
        checks++; if (obs_cdi_hold !== ((mode == 0 && !blocked) ? rdv : 8'hFF)) begin errors++;
          $display("FAIL rnd_cdi[%0d]: got %h want %h", n, obs_cdi_hold, (mode == 0 && !blocked) ? rdv : 8'hFF); end
      end
      checks++; if (obs_cdi_after !== 8'hFF) begin errors++;
        $display("FAIL rnd_cdi_after[%0d]: got %h want ff", n, obs_cdi_after); end
    end
  endtask

  task automatic test_timeout();
`ifdef Z88_MEMCTL_TIMEOUT_EN
    run_txn(5'b11101, 1'b1, 1'b0, 22'h000777, 8'h00, 0, 8'h5A, 1);
    checks++; if (obs_wait_low != 1 + TO) begin errors++; $display("FAIL to_wait: got %0d want %0d", obs_wait_low, 1 + TO); end
    checks++; if (obs_pulses != 1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL to_req: got pulses=%0d req=%b want 1/0", obs_pulses, mem_req); end
    checks++; if (obs_cdi_hold !== 8'hFF) begin errors++; $display("FAIL to_cdi: got %h want ff", obs_cdi_hold); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
`else
    int low = 0;
    @(posedge clk); #1;
    ma = 22'h000777; cs_n = 5'b11101; roe_n = 1'b0; ack_delay = 0;
    repeat (300) begin @(negedge clk); if (wait_n === 1'b0) low++; end
    checks++; if (low != 300 || mem_req !== 1'b1) begin errors++;
      $display("FAIL no_to_wait: got low=%0d req=%b want 300/1", low, mem_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL no_to_err: got %b want 0", err); end
    #1 reset_n = 1'b0;
    roe_n = 1'b1; cs_n = '1;
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ma = 22'h012345; cs_n = 5'b11101; roe_n = 1'b0; wrb_n = 1'b1; ack_delay = 0;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_in_req: got %b want 1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || wait_n !== 1'b1 || cdi !== 8'hFF || err !== 1'b0) begin errors++;
      $display("FAIL rm_async: got req=%b wait_n=%b cdi=%h err=%b want 0/1/ff/0", mem_req, wait_n, cdi, err); end
    checks++; if ({mem_we, mem_sel, mem_a, mem_wd} !== '0) begin errors++;
      $display("FAIL rm_port: got we=%b sel=%0d a=%h wd=%h want all 0", mem_we, mem_sel, mem_a, mem_wd); end
    roe_n = 1'b1; cs_n = '1;
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1 inject_ack = 1'b1;
    @(posedge clk); #1 inject_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || wait_n !== 1'b1) begin errors++;
      $display("FAIL rm_late_ack: got req=%b wait_n=%b want 0/1", mem_req, wait_n); end
    run_txn(5'b11101, 1'b1, 1'b0, 22'h000ABC, 8'h00, 2, 8'hE7, 0);
    checks++; if (obs_wait_low != 3 || obs_cdi_hold !== 8'hE7 || obs_pulses != 1) begin errors++;
      $display("FAIL rm_next: got wait=%0d cdi=%h pulses=%0d want 3/e7/1", obs_wait_low, obs_cdi_hold, obs_pulses); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ma = '0; cs_n = '1; roe_n = 1'b1; wrb_n = 1'b1; cdo = '0;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_ro_write();
    test_priority();
    test_strobe_drop();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
